vram_bus_arbiter: RTL
=====================

// Module: vram_bus_arbiter
// PURPOSE
//  Shares the single-port synchronous VRAM between the display tile fetcher (hpu) and a
//  host (CPU) access port. Display reads have absolute priority and are never stalled;
//  host reads/writes are buffered in a holding register and issued in free bus cycles.
//  Sits between hpu.addr_out/data_in, the host bus and the VRAM macro (1-cycle read latency).
// PARAMETERS
//  ADDR_W       16       VRAM address width
//  DATA_W       8        VRAM data width
//  STARVE_LIMIT 64       host_starved asserts when stall_count >= this value
//  PROTECT_TOP  16'h1800 first writable address (VRAM_WRITE_PROTECT_EN only; tile area below)
// PORTS
//  clk          in  1       clock
//  reset        in  1       asynchronous, active-high reset
//  disp_req     in  1       display fetcher needs the bus this cycle
//  disp_addr    in  ADDR_W  display read address
//  disp_data    out DATA_W  = mem_rdata (combinational pass-through)
//  host_req     in  1       host request, level, sampled only in IDLE
//  host_we      in  1       1 = write, 0 = read
//  host_addr    in  ADDR_W  host address
//  host_wdata   in  DATA_W  host write data
//  host_ack     out 1       one-cycle completion pulse
//  host_rdata   out DATA_W  read data, valid from the host_ack cycle until next read completes
//  host_busy    out 1       1 whenever state != IDLE
//  host_starved out 1       stall_count >= STARVE_LIMIT
//  stall_count  out 8       cycles current host request lost to display, saturates at 255
//  mem_addr     out ADDR_W  VRAM address (combinational)
//  mem_we       out 1       VRAM write enable (combinational)
//  mem_wdata    out DATA_W  VRAM write data = held wdata
//  mem_rdata    in  DATA_W  VRAM read data, valid 1 cycle after address
// BEHAVIOUR
//  - Reset: state IDLE; host_ack 0, host_rdata 0, stall_count 0, holding regs 0; mem_we 0.
//  - Bus mux: issue = (state==PEND) && !disp_req. issue: mem_addr=hold_addr, mem_we=hold_we.
//    Otherwise mem_addr=disp_addr, mem_we=0. Display never waits, even the cycle after a host issue.
//  - FSM states and transitions:
//    IDLE : host_req=1 -> latch addr/we/wdata, stall_count<=0, -> PEND.
//    PEND : disp_req=1 -> stay, stall_count+1 (saturating 255).
//           disp_req=0 -> issue; write -> ACK, read -> RDATA.
//    RDATA: host_rdata <= mem_rdata (data of the host address issued last cycle) -> ACK.
//    ACK  : host_ack=1 for exactly this cycle -> IDLE.
//  - Latency (no contention): write ack 2 cycles after the req sample edge, read ack 3 cycles.
//  - host_req still high in IDLE after ACK starts a new transaction; host drops req on host_ack.
//  - host_req/inputs changing while busy are ignored (held copy is used).
//  - Simultaneous disp_req and host issue: display wins; host retries every cycle, no loss.
//  - stall_count holds its value in RDATA/ACK/IDLE until the next request is latched.
//  - Reset mid-operation: transaction aborted immediately; no mem_we, no host_ack.
// CONFIGURATION
//  VRAM_WRITE_PROTECT_EN defined: extra port prot_err (out, 1, sticky, cleared by reset only).
//    Host write with hold_addr < PROTECT_TOP: mem_we stays 0 at issue, still acked, prot_err<=1.
//    Reads are unaffected.
//  Undefined: no prot_err port; all host writes reach VRAM.
// TESTING
//  1 disp_req=0, write 0x2700<-0x5A: mem_we=1 one cycle, addr 0x2700 data 0x5A; ack at +2.
//  2 disp_req=0, read 0x1805, VRAM holds 0x3C: host_rdata=0x3C with host_ack at +3.
//  3 host write pending, disp_req high 10 cycles: mem_addr=disp_addr, no mem_we throughout;
//    stall_count=10; write issues first cycle disp_req=0.
//  4 disp_req held 70 cycles with host pending: host_starved rises when stall_count reaches 64.
//  5 reset asserted while in PEND: no mem_we, no host_ack; all outputs at reset values.
//  6 VRAM_WRITE_PROTECT_EN, write 0x0100: no mem_we, ack, prot_err=1; undefined: write occurs.

Source files
------------

// File: rtl/vram_bus_arbiter.sv
// VRAM bus arbiter: display fetcher has absolute priority, host accesses are held and issued in free cycles.
// Optional write protection of the tile area below PROTECT_TOP is enabled by defining VRAM_WRITE_PROTECT_EN.
module vram_bus_arbiter #(
    parameter int unsigned ADDR_W       = 16,
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned STARVE_LIMIT = 64,
    parameter logic [ADDR_W-1:0] PROTECT_TOP = ADDR_W'(16'h1800)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic [DATA_W-1:0] disp_data,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_ack,
    output logic [DATA_W-1:0] host_rdata,
    output logic              host_busy,
    output logic              host_starved,
    output logic [7:0]        stall_count,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef VRAM_WRITE_PROTECT_EN
    ,
    output logic              prot_err
`endif
);

    localparam int unsigned CNT_W   = 8;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(8'hFF);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PEND  = 2'd1,
        RDATA = 2'd2,
        ACK   = 2'd3
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] hold_addr;
    logic              hold_we;
    logic [DATA_W-1:0] hold_wdata;
    logic              issue;
    logic              blocked;

    // Host owns the bus only in a PEND cycle the display leaves free.
    assign issue = (state == PEND) && !disp_req;

`ifdef VRAM_WRITE_PROTECT_EN
    assign blocked = hold_we && (hold_addr < PROTECT_TOP);
`else
    assign blocked = 1'b0;
`endif

    assign mem_addr     = issue ? hold_addr : disp_addr;
    assign mem_we       = issue && hold_we && !blocked;
    assign mem_wdata    = hold_wdata;
    assign disp_data    = mem_rdata;
    assign host_busy    = (state != IDLE);
    assign host_starved = (32'(stall_count) >= STARVE_LIMIT);

    // Host transaction FSM; host_ack is high exactly in the ACK state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            hold_addr   <= '0;
            hold_we     <= 1'b0;
            hold_wdata  <= '0;
            host_ack    <= 1'b0;
            host_rdata  <= '0;
            stall_count <= '0;
`ifdef VRAM_WRITE_PROTECT_EN
            prot_err    <= 1'b0;
`endif
        end else begin
            host_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (host_req) begin
                        hold_addr   <= host_addr;
                        hold_we     <= host_we;
                        hold_wdata  <= host_wdata;
                        stall_count <= '0;
                        state       <= PEND;
                    end
                end
                PEND: begin
                    if (disp_req) begin
                        if (stall_count != CNT_MAX) begin
                            stall_count <= stall_count + CNT_W'(1);
                        end
                    end else begin
                        state    <= hold_we ? ACK : RDATA;
                        host_ack <= hold_we;
`ifdef VRAM_WRITE_PROTECT_EN
                        if (blocked) begin
                            prot_err <= 1'b1;
                        end
`endif
                    end
                end
                RDATA: begin
                    host_rdata <= mem_rdata;
                    host_ack   <= 1'b1;
                    state      <= ACK;
                end
                ACK: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
